lcd_tx_sequencer: RTL and testbench

Sequences the 4-bit LCD bus for the character-LCD driver. It arbitrates between the initialization FSM and the display-refresh FSM, accepting one 10-bit command word at a time. Each word is split into nibbles, E pulse timing is generated, and the post-command execution delay is enforced. It sits between the command sources and the LCD pins and is the only block that drives lcd_e, lcd_rs, lcd_rw and lcd_db.

---
 rtl/lcd_tx_sequencer.sv | 194 +++++++++++++++++++
 tb/tb_lcd_tx_sequencer.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lcd_tx_sequencer.sv
// lcd_tx_sequencer: arbitrates init/refresh command words and drives the 4-bit
// character-LCD bus with setup, E pulse, hold, inter-nibble gap and
// post-command execution delay.
// Optional feature macro: LCD_TX_LONG_WAIT_EN (clear/home commands wait T_LONG).
`timescale 1ns/1ps
module lcd_tx_sequencer #(
    parameter int unsigned T_SU   = 2,
    parameter int unsigned T_PW   = 12,
    parameter int unsigned T_H    = 1,
    parameter int unsigned T_GAP  = 50,
    parameter int unsigned T_CMD  = 2000,
    parameter int unsigned T_LONG = 82000,
    parameter int unsigned CNT_W  = 17
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        init_req,
    input  logic [9:0]  init_data,
    input  logic        init_nib,
    input  logic        init_done,
    output logic        init_ack,
    input  logic        refresh_req,
    input  logic [9:0]  refresh_data,
    output logic        refresh_ack,
    output logic        busy,
    output logic        lcd_e,
    output logic        lcd_rs,
    output logic        lcd_rw,
    output logic [3:0]  lcd_db
);

    localparam int unsigned DATA_W = 10;
    localparam int unsigned NIB_W  = 4;

    typedef enum logic [3:0] {
        IDLE,
        SETUP_HI,
        PULSE_HI,
        HOLD_HI,
        GAP,
        SETUP_LO,
        PULSE_LO,
        HOLD_LO,
        WAIT_CMD
    } state_t;

    state_t             state, state_nx;
    logic [CNT_W-1:0]   cnt, cnt_nx;
    logic [NIB_W-1:0]   lo_nib, lo_nib_nx;
    logic               nib_only, nib_only_nx;
    logic               long_q, long_nx;
    logic               init_ack_nx, refresh_ack_nx, busy_nx;
    logic               e_nx, rs_nx, rw_nx;
    logic [NIB_W-1:0]   db_nx;
    logic [DATA_W-1:0]  gnt_data;
    logic               gnt_nib, gnt_long, cnt_last;
    int unsigned        state_len;

    // Select the word that would be granted; init always has priority
    always_comb begin
        gnt_data = init_req ? init_data : refresh_data;
        gnt_nib  = init_req & init_nib;
`ifdef LCD_TX_LONG_WAIT_EN
        gnt_long = !gnt_nib && (gnt_data[9:8] == 2'b00) &&
                   ((gnt_data[7:0] == 8'h01) || (gnt_data[7:0] == 8'h02) ||
                    (gnt_data[7:0] == 8'h03));
`else
        gnt_long = 1'b0;
`endif
    end

    // Duration of the current state and terminal-count detect
    always_comb begin
        state_len = 1;
        case (state)
            SETUP_HI, SETUP_LO: state_len = T_SU;
            PULSE_HI, PULSE_LO: state_len = T_PW;
            HOLD_HI, HOLD_LO:   state_len = T_H;
            GAP:                state_len = T_GAP;
            WAIT_CMD:           state_len = long_q ? T_LONG : T_CMD;
            default:            state_len = 1;
        endcase
        cnt_last = (cnt == CNT_W'(state_len - 1));
    end

    // Next-state, counter and next registered output values
    always_comb begin
        state_nx       = state;
        cnt_nx         = cnt + CNT_W'(1);
        lo_nib_nx      = lo_nib;
        nib_only_nx    = nib_only;
        long_nx        = long_q;
        init_ack_nx    = 1'b0;
        refresh_ack_nx = 1'b0;
        rs_nx          = lcd_rs;
        rw_nx          = lcd_rw;
        db_nx          = lcd_db;

        case (state)
            IDLE: begin
                cnt_nx = '0;
                rs_nx  = 1'b0;
                rw_nx  = 1'b0;
                db_nx  = '0;
                if (init_req || (refresh_req && init_done)) begin
                    init_ack_nx    = init_req;
                    refresh_ack_nx = !init_req;
                    lo_nib_nx      = gnt_data[3:0];
                    nib_only_nx    = gnt_nib;
                    long_nx        = gnt_long;
                    rs_nx          = gnt_data[9];
                    rw_nx          = gnt_data[8];
                    db_nx          = gnt_nib ? gnt_data[3:0] : gnt_data[7:4];
                    state_nx       = SETUP_HI;
                end
            end
            SETUP_HI: if (cnt_last) begin
                cnt_nx   = '0;
                state_nx = PULSE_HI;
            end
            PULSE_HI: if (cnt_last) begin
                cnt_nx   = '0;
                state_nx = HOLD_HI;
            end
            HOLD_HI: if (cnt_last) begin
                cnt_nx   = '0;
                state_nx = nib_only ? WAIT_CMD : GAP;
            end
            GAP: if (cnt_last) begin
                cnt_nx   = '0;
                db_nx    = lo_nib;
                state_nx = SETUP_LO;
            end
            SETUP_LO: if (cnt_last) begin
                cnt_nx   = '0;
                state_nx = PULSE_LO;
            end
            PULSE_LO: if (cnt_last) begin
                cnt_nx   = '0;
                state_nx = HOLD_LO;
            end
            HOLD_LO: if (cnt_last) begin
                cnt_nx   = '0;
                state_nx = WAIT_CMD;
            end
            WAIT_CMD: if (cnt_last) begin
                cnt_nx   = '0;
                rs_nx    = 1'b0;
                rw_nx    = 1'b0;
                db_nx    = '0;
                state_nx = IDLE;
            end
            default: begin
                cnt_nx   = '0;
                state_nx = IDLE;
            end
        endcase

        e_nx    = (state_nx == PULSE_HI) || (state_nx == PULSE_LO);
        busy_nx = (state_nx != IDLE);
    end

    // State, counter, captured word and registered outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            cnt         <= '0;
            lo_nib      <= '0;
            nib_only    <= 1'b0;
            long_q      <= 1'b0;
            init_ack    <= 1'b0;
            refresh_ack <= 1'b0;
            busy        <= 1'b0;
            lcd_e       <= 1'b0;
            lcd_rs      <= 1'b0;
            lcd_rw      <= 1'b0;
            lcd_db      <= '0;
        end else begin
            state       <= state_nx;
            cnt         <= cnt_nx;
            lo_nib      <= lo_nib_nx;
            nib_only    <= nib_only_nx;
            long_q      <= long_nx;
            init_ack    <= init_ack_nx;
            refresh_ack <= refresh_ack_nx;
            busy        <= busy_nx;
            lcd_e       <= e_nx;
            lcd_rs      <= rs_nx;
            lcd_rw      <= rw_nx;
            lcd_db      <= db_nx;
        end
    end

endmodule

// File: tb/tb_lcd_tx_sequencer.sv
// Testbench for lcd_tx_sequencer: directed scenarios plus random command words,
// each bus transaction captured cycle by cycle and checked against timing
// expectations computed from the command word.
`timescale 1ns/1ps
module tb_lcd_tx_sequencer;

    localparam int T_SU   = 2;
    localparam int T_PW   = 12;
    localparam int T_H    = 1;
    localparam int T_GAP  = 50;
    localparam int T_CMD  = 2000;
    localparam int T_LONG = 82000;
`ifdef LCD_TX_LONG_WAIT_EN
    localparam int TR_MAX  = 82300;
    localparam bit LONG_EN = 1'b1;
    localparam int N_RAND  = 2;
`else
    localparam int TR_MAX  = 2300;
    localparam bit LONG_EN = 1'b0;
    localparam int N_RAND  = 12;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic       init_req, init_nib, init_done, refresh_req;
    logic [9:0] init_data, refresh_data;
    logic       init_ack, refresh_ack, busy;
    logic       lcd_e, lcd_rs, lcd_rw;
    logic [3:0] lcd_db;

    int n_cmp = 0;
    int n_err = 0;

    logic       tr_e   [TR_MAX];
    logic       tr_rs  [TR_MAX];
    logic       tr_rw  [TR_MAX];
    logic       tr_ack [TR_MAX];
    logic [3:0] tr_db  [TR_MAX];

    lcd_tx_sequencer dut (
        .clk          (clk),
        .reset        (reset),
        .init_req     (init_req),
        .init_data    (init_data),
        .init_nib     (init_nib),
        .init_done    (init_done),
        .init_ack     (init_ack),
        .refresh_req  (refresh_req),
        .refresh_data (refresh_data),
        .refresh_ack  (refresh_ack),
        .busy         (busy),
        .lcd_e        (lcd_e),
        .lcd_rs       (lcd_rs),
        .lcd_rw       (lcd_rw),
        .lcd_db       (lcd_db)
    );

    always #10 clk = ~clk;

    initial begin
        #(20 * 200000);
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    // Reference: execution delay of a command word
    function automatic int exp_wait(input logic [9:0] d, input logic nb);
        if (LONG_EN && !nb && d[9:8] == 2'b00 && d[7:0] >= 8'h01 && d[7:0] <= 8'h03)
            return T_LONG;
        return T_CMD;
    endfunction

    // Issue one request, capture the whole bus transaction and check it
    task automatic run_cmd(input bit src, input logic [9:0] d, input logic nb,
                           input string name, output int lat);
        int         n, pulses, exp_n, exp_busy, nw;
        int         ps [4];
        int         pl [4];
        int         exp_s [2];
        logic [3:0] exp_v [2];
        bit         got_ack, other, bad;
        if (!src) begin
            init_data = d; init_nib = nb; init_req = 1'b1;
        end else begin
            refresh_data = d; refresh_req = 1'b1;
        end
        lat = 0; other = 1'b0; got_ack = 1'b0;
        while (!got_ack && lat < 20) begin
            @(negedge clk);
            lat++;
            if (src ? init_ack : refresh_ack) other = 1'b1;
            got_ack = src ? refresh_ack : init_ack;
        end
        if (!src) init_req = 1'b0; else refresh_req = 1'b0;
        n_cmp++;
        if (!got_ack) begin
            n_err++;
            $display("FAIL %s ack_timeout: got no ack, want ack within 20 cycles", name);
            return;
        end
        n = 0;
        while (busy === 1'b1 && n < TR_MAX) begin
            tr_e[n] = lcd_e; tr_rs[n] = lcd_rs; tr_rw[n] = lcd_rw;
            tr_db[n] = lcd_db; tr_ack[n] = src ? refresh_ack : init_ack;
            n++;
            @(negedge clk);
            if (src ? init_ack : refresh_ack) other = 1'b1;
        end

        n_cmp++;
        if (other) begin
            n_err++;
            $display("FAIL %s other_ack: got other source ack=1, want 0", name);
        end
        n_cmp++;
        if (n < 2 || tr_ack[1] !== 1'b0) begin
            n_err++;
            $display("FAIL %s ack_width: got ack still high in 2nd cycle (n=%0d), want 1-cycle pulse", name, n);
        end

        // Expected transaction from the command word
        nw = exp_wait(d, nb);
        if (nb) begin
            exp_n = 1; exp_s[0] = T_SU; exp_v[0] = d[3:0];
            exp_s[1] = 0; exp_v[1] = 4'h0;
            exp_busy = T_SU + T_PW + T_H + nw;
        end else begin
            exp_n = 2;
            exp_s[0] = T_SU; exp_v[0] = d[7:4];
            exp_s[1] = T_SU + T_PW + T_H + T_GAP + T_SU; exp_v[1] = d[3:0];
            exp_busy = 2 * (T_SU + T_PW + T_H) + T_GAP + nw;
        end

        n_cmp++;
        if (n !== exp_busy) begin
            n_err++;
            $display("FAIL %s busy_len: got %0d cycles, want %0d", name, n, exp_busy);
        end

        pulses = 0;
        for (int i = 0; i < n; i++) begin
            if (tr_e[i] === 1'b1 && (i == 0 || tr_e[i-1] !== 1'b1)) begin
                if (pulses < 4) begin ps[pulses] = i; pl[pulses] = 0; end
                pulses++;
            end
            if (tr_e[i] === 1'b1 && pulses > 0 && pulses <= 4) pl[pulses-1]++;
        end
        n_cmp++;
        if (pulses !== exp_n) begin
            n_err++;
            $display("FAIL %s e_pulse_count: got %0d, want %0d", name, pulses, exp_n);
        end
        for (int j = 0; j < exp_n && j < pulses; j++) begin
            n_cmp++;
            if (ps[j] !== exp_s[j] || pl[j] !== T_PW) begin
                n_err++;
                $display("FAIL %s e_pulse%0d: got start %0d len %0d, want start %0d len %0d",
                         name, j, ps[j], pl[j], exp_s[j], T_PW);
            end
        end
        for (int j = 0; j < exp_n; j++) begin
            bad = 1'b0;
            for (int k = exp_s[j] - T_SU; k < exp_s[j] + T_PW + T_H; k++) begin
                if (k >= n) bad = 1'b1;
                else if (tr_db[k] !== exp_v[j] || tr_rs[k] !== d[9] || tr_rw[k] !== d[8]) bad = 1'b1;
            end
            n_cmp++;
            if (bad) begin
                n_err++;
                $display("FAIL %s nibble%0d_window: got db=%h rs=%b rw=%b at E rise, want db=%h rs=%b rw=%b stable",
                         name, j, tr_db[exp_s[j] < n ? exp_s[j] : 0], tr_rs[exp_s[j] < n ? exp_s[j] : 0],
                         tr_rw[exp_s[j] < n ? exp_s[j] : 0], exp_v[j], d[9], d[8]);
            end
        end

        n_cmp++;
        if ({lcd_e, lcd_rs, lcd_rw, lcd_db} !== 7'b0) begin
            n_err++;
            $display("FAIL %s idle_outputs: got e=%b rs=%b rw=%b db=%h, want all 0",
                     name, lcd_e, lcd_rs, lcd_rw, lcd_db);
        end
    endtask

    task automatic test_reset();
        bit bad = 1'b0;
        reset = 1'b0; init_req = 1'b0; init_nib = 1'b0; init_done = 1'b0;
        refresh_req = 1'b0; init_data = '0; refresh_data = '0;
        repeat (5) begin
            @(negedge clk);
            if ({init_ack, refresh_ack, busy, lcd_e, lcd_rs, lcd_rw, lcd_db} !== 10'b0) bad = 1'b1;
        end
        n_cmp++;
        if (bad) begin
            n_err++;
            $display("FAIL reset_outputs: got nonzero output in reset, want all 0");
        end
        reset = 1'b1;
        bad = 1'b0;
        repeat (100) begin
            @(negedge clk);
            if ({init_ack, refresh_ack, busy, lcd_e, lcd_rs, lcd_rw, lcd_db} !== 10'b0) bad = 1'b1;
        end
        n_cmp++;
        if (bad) begin
            n_err++;
            $display("FAIL idle_after_reset: got nonzero output/busy, want all 0 for 100 cycles");
        end
    endtask

    task automatic test_refresh_a();
        int lat;
        init_done = 1'b1;
        run_cmd(1'b1, 10'h241, 1'b0, "refresh_A", lat);
    endtask

    task automatic test_init_nibble();
        int lat;
        @(negedge clk);
        run_cmd(1'b0, 10'h003, 1'b1, "init_nibble", lat);
    endtask

    task automatic test_clear();
        int lat;
        @(negedge clk);
        run_cmd(1'b0, 10'h001, 1'b0, "clear_display", lat);
    endtask

    task automatic test_arbitration();
        int lat;
        bit bad = 1'b0;
        init_done = 1'b0;
        refresh_data = 10'h248;
        refresh_req = 1'b1;
        repeat (100) begin
            @(negedge clk);
            if (refresh_ack !== 1'b0 || busy !== 1'b0) bad = 1'b1;
        end
        n_cmp++;
        if (bad) begin
            n_err++;
            $display("FAIL arb_no_init_done: got refresh_ack/busy, want none while init_done=0");
        end
        refresh_req = 1'b0;
        @(negedge clk);
        init_done = 1'b1;
        refresh_req = 1'b1;
        run_cmd(1'b0, 10'h028, 1'b0, "arb_init_first", lat);
        run_cmd(1'b1, 10'h248, 1'b0, "arb_refresh_second", lat);
        n_cmp++;
        if (lat !== 1) begin
            n_err++;
            $display("FAIL arb_refresh_latency: got ack %0d cycles after idle, want 1", lat);
        end
    endtask

    task automatic test_reset_mid_pulse();
        int  lat, cnt;
        init_done = 1'b1;
        refresh_data = 10'h253;
        refresh_req = 1'b1;
        cnt = 0;
        @(negedge clk);
        while (refresh_ack !== 1'b1 && cnt < 20) begin @(negedge clk); cnt++; end
        refresh_req = 1'b0;
        cnt = 0;
        while (lcd_e !== 1'b1 && cnt < 20) begin @(negedge clk); cnt++; end
        n_cmp++;
        if (lcd_e !== 1'b1) begin
            n_err++;
            $display("FAIL rst_mid_reach_pulse: got lcd_e=%b, want 1 before reset", lcd_e);
        end
        init_data = 10'h00c; init_nib = 1'b0; init_req = 1'b1;
        repeat (3) @(negedge clk);
        #3 reset = 1'b0;
        #1;
        n_cmp++;
        if ({lcd_e, busy, lcd_rs, lcd_rw, lcd_db} !== 8'b0) begin
            n_err++;
            $display("FAIL rst_mid_async: got e=%b busy=%b rs=%b db=%h, want all 0 immediately",
                     lcd_e, busy, lcd_rs, lcd_db);
        end
        @(negedge clk);
        reset = 1'b1;
        run_cmd(1'b0, 10'h00c, 1'b0, "rst_mid_regrant", lat);
        n_cmp++;
        if (lat !== 1) begin
            n_err++;
            $display("FAIL rst_mid_regrant_latency: got %0d, want 1", lat);
        end
    endtask

    task automatic test_random();
        int         lat;
        bit         src;
        logic [9:0] d;
        logic       nb;
        for (int i = 0; i < N_RAND; i++) begin
            src = 1'($urandom % 2);
            d   = 10'($urandom);
            nb  = src ? 1'b0 : 1'($urandom % 2);
            if (exp_wait(d, nb) == T_LONG) d[7:0] = 8'h41;
            repeat ($urandom_range(0, 5)) @(negedge clk);
            run_cmd(src, d, nb, "random", lat);
            n_cmp++;
            if (lat !== 1) begin
                n_err++;
                $display("FAIL random_latency: got %0d, want 1 (word %h)", lat, d);
            end
        end
    endtask

    initial begin
        test_reset();
        test_refresh_a();
        test_init_nibble();
        test_clear();
        test_arbitration();
        test_reset_mid_pulse();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
